// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  // Records which requester owns the RAM read slot, so the response is
  // routed back to the right port one cycle later.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = 2;

endpackage : mem_arb_pkg

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive instruction-fetch losses. at_max tells
// the arbiter that fetch has waited long enough and must win the next
// collision.
module arb_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  // Count losses, saturate at MAX; a grant or an idle fetch port restarts the count.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : arb_starve_ctr

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between the core's instruction-fetch
// port and its data port. Data wins collisions unless fetch has been starved
// for STARVE_MAX consecutive cycles. Read data returns one cycle after grant.
// Misaligned data accesses never touch the RAM and answer with an error.
// Optional build macro: ARB_PERF_CNT_EN adds per-port stall-cycle counters.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RAM_AW     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       i_stall_cnt,
  output logic [31:0]       d_stall_cnt,
`endif
  input  logic [31:0]       ram_dout
);

  owner_t            owner_q;
  owner_t            owner_d;
  logic              err_q;
  logic [RAM_AW-1:0] addr_q;
  logic [RAM_AW-1:0] addr_sel;
  logic              d_mis;
  logic              d_ram;
  logic              starve_max;
  logic              unused;

  // Byte-offset bits of the fetch address and all bits above the RAM word
  // index are deliberately ignored, so addresses wrap modulo the RAM size.
  assign unused = ^{i_addr[ADDR_W-1:RAM_AW+BYTE_OFF_W], i_addr[BYTE_OFF_W-1:0],
                    d_addr[ADDR_W-1:RAM_AW+BYTE_OFF_W]};

  assign d_mis = (d_addr[BYTE_OFF_W-1:0] != '0);

  // Per-cycle grant decision and RAM port drive; a misaligned data access is
  // accepted without using the RAM, leaving the slot free for fetch.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    d_ram    = 1'b0;
    ram_we   = 1'b0;
    ram_din  = '0;
    addr_sel = addr_q;
    owner_d  = OWN_NONE;
    if (!rst) begin
      d_gnt = d_req & (d_mis | ~(i_req & starve_max));
      i_gnt = i_req & (~d_req | d_mis | starve_max);
    end
    d_ram = d_gnt & ~d_mis;
    if (d_ram) begin
      addr_sel = d_addr[RAM_AW+BYTE_OFF_W-1:BYTE_OFF_W];
      owner_d  = OWN_DATA;
      ram_we   = d_wen;
      ram_din  = d_wen ? d_wdata : '0;
    end else if (i_gnt) begin
      addr_sel = i_addr[RAM_AW+BYTE_OFF_W-1:BYTE_OFF_W];
      owner_d  = OWN_INST;
    end
    ram_addr = rst ? '0 : addr_sel;
  end

  // Remember the slot owner, any pending error and the last RAM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      owner_q <= owner_d;
      err_q   <= d_gnt & d_mis;
      addr_q  <= addr_sel;
    end
  end

  // Route the RAM output to whichever port owned last cycle's slot; reset
  // suppresses any response still in flight.
  always_comb begin
    i_rvalid = !rst && (owner_q == OWN_INST);
    i_rdata  = i_rvalid ? ram_dout : '0;
    d_err    = !rst && err_q;
    d_rvalid = !rst && ((owner_q == OWN_DATA) || err_q);
    d_rdata  = (!rst && (owner_q == OWN_DATA)) ? ram_dout : '0;
  end

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (i_req & ~i_gnt),
    .clr    (~i_req | i_gnt),
    .at_max (starve_max)
  );

`ifdef ARB_PERF_CNT_EN
  // Stall-cycle counters: one tick per cycle a request is held but not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      i_stall_cnt <= i_stall_cnt + 32'(i_req & ~i_gnt);
      d_stall_cnt <= d_stall_cnt + 32'(d_req & ~d_gnt);
    end
  end
`endif

endmodule : unified_mem_arbiter

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a table of directed vectors
// applied back-to-back, plus hand-written collision and reset sequences.
// Build with ARB_PERF_CNT_EN defined to also check the stall counters.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_wen;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_stall_cnt, d_stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .RAM_AW(10), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
`ifdef ARB_PERF_CNT_EN
    .i_stall_cnt (i_stall_cnt),
    .d_stall_cnt (d_stall_cnt),
`endif
    .ram_dout (ram_dout)
  );

  // Behavioural single-port RAM with registered read (read-before-write).
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " i_gnt"},    32'(i_gnt),    32'd0);
    check({tag, " d_gnt"},    32'(d_gnt),    32'd0);
    check({tag, " ram_we"},   32'(ram_we),   32'd0);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " i_rvalid"}, 32'(i_rvalid), 32'd0);
    check({tag, " i_rdata"},  i_rdata,       32'd0);
    check({tag, " d_rvalid"}, 32'(d_rvalid), 32'd0);
    check({tag, " d_err"},    32'(d_err),    32'd0);
    check({tag, " d_rdata"},  d_rdata,       32'd0);
  endtask

  // Inputs for this cycle, expected request-side outputs this cycle, and
  // expected response outputs (answering the previous vector).
  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_i_gnt;
    logic        e_d_gnt;
    logic        e_we;
    logic [9:0]  e_addr;
    logic        e_i_rvalid;
    logic [31:0] e_i_rdata;
    logic        e_d_rvalid;
    logic        e_d_err;
    logic        chk_drdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2] = 32'hA5A5_0002;
    mem[5] = 32'h0000_5555;

    //            ir ia            dr dw da            dd            ig dg we addr iv ird           dv de cd drd
    vecs[0]  = '{1, 32'h8,        0, 0, 32'h0,        32'h0,        1, 0, 0, 10'd2, 0, 32'h0,        0, 0, 1, 32'h0};
    vecs[1]  = '{0, 32'h0,        1, 1, 32'h10,       32'hDEADBEEF, 0, 1, 1, 10'd4, 1, 32'hA5A50002, 0, 0, 1, 32'h0};
    vecs[2]  = '{0, 32'h0,        1, 0, 32'h10,       32'h0,        0, 1, 0, 10'd4, 0, 32'h0,        1, 0, 0, 32'h0};
    vecs[3]  = '{1, 32'h14,       1, 0, 32'h6,        32'h0,        1, 1, 0, 10'd5, 0, 32'h0,        1, 0, 1, 32'hDEADBEEF};
    vecs[4]  = '{0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 10'd5, 1, 32'h00005555, 1, 1, 1, 32'h0};
    vecs[5]  = '{0, 32'h0,        1, 1, 32'h13,       32'hFFFFFFFF, 0, 1, 0, 10'd5, 0, 32'h0,        0, 0, 1, 32'h0};
    vecs[6]  = '{1, 32'h10000008, 0, 0, 32'h0,        32'h0,        1, 0, 0, 10'd2, 0, 32'h0,        1, 1, 1, 32'h0};
    vecs[7]  = '{0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 10'd2, 1, 32'hA5A50002, 0, 0, 1, 32'h0};
    vecs[8]  = '{0, 32'h0,        1, 0, 32'h10,       32'h0,        0, 1, 0, 10'd4, 0, 32'h0,        0, 0, 1, 32'h0};
    vecs[9]  = '{0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 10'd4, 0, 32'h0,        1, 0, 1, 32'hDEADBEEF};
    vecs[10] = '{1, 32'h0,        1, 0, 32'h8,        32'h0,        0, 1, 0, 10'd2, 0, 32'h0,        0, 0, 1, 32'h0};
    vecs[11] = '{0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 10'd2, 0, 32'h0,        1, 0, 1, 32'hA5A50002};

    // Reset state.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    check_all_zero("reset");
`ifdef ARB_PERF_CNT_EN
    check("reset i_stall_cnt", i_stall_cnt, 32'd0);
    check("reset d_stall_cnt", d_stall_cnt, 32'd0);
`endif
    next_cycle();
    rst = 1'b0;

    // Directed vectors, applied back-to-back.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].i_req, vecs[i].i_addr, vecs[i].d_req, vecs[i].d_wen,
            vecs[i].d_addr, vecs[i].d_wdata);
      @(negedge clk);
      check($sformatf("v%0d i_gnt", i),    32'(i_gnt),    32'(vecs[i].e_i_gnt));
      check($sformatf("v%0d d_gnt", i),    32'(d_gnt),    32'(vecs[i].e_d_gnt));
      check($sformatf("v%0d ram_we", i),   32'(ram_we),   32'(vecs[i].e_we));
      check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_we) check($sformatf("v%0d ram_din", i), ram_din, vecs[i].d_wdata);
      check($sformatf("v%0d i_rvalid", i), 32'(i_rvalid), 32'(vecs[i].e_i_rvalid));
      if (vecs[i].e_i_rvalid) check($sformatf("v%0d i_rdata", i), i_rdata, vecs[i].e_i_rdata);
      check($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_d_rvalid));
      check($sformatf("v%0d d_err", i),    32'(d_err),    32'(vecs[i].e_d_err));
      if (vecs[i].e_d_rvalid && vecs[i].chk_drdata)
        check($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_d_rdata);
      next_cycle();
    end

    // Fresh reset so the stall counters start from zero for the collision run.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;

    // Collision: both held, data wins four times, fetch the fifth, repeating.
    drive(1, 32'h20, 1, 0, 32'h24, 32'h0);
    for (int k = 0; k < 15; k++) begin
      logic exp_i;
      exp_i = ((k % 5) == 4);
      @(negedge clk);
      check($sformatf("coll%0d i_gnt", k),    32'(i_gnt),    32'(exp_i));
      check($sformatf("coll%0d d_gnt", k),    32'(d_gnt),    32'(!exp_i));
      check($sformatf("coll%0d ram_addr", k), 32'(ram_addr), exp_i ? 32'd8 : 32'd9);
      if (k > 0) begin
        check($sformatf("coll%0d i_rvalid", k), 32'(i_rvalid), 32'(((k - 1) % 5) == 4));
        check($sformatf("coll%0d d_rvalid", k), 32'(d_rvalid), 32'(((k - 1) % 5) != 4));
      end
`ifdef ARB_PERF_CNT_EN
      if (k == 10) begin
        check("perf i_stall_cnt", i_stall_cnt, 32'd8);
        check("perf d_stall_cnt", d_stall_cnt, 32'd2);
      end
`endif
      next_cycle();
    end

    // Build up three fetch losses, then reset the cycle after a data grant.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("pre_rst%0d d_gnt", k), 32'(d_gnt), 32'd1);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    next_cycle();
    rst = 1'b0;

    // Starvation count must restart: four data wins before fetch wins again,
    // and no response leaks out of the dropped transaction.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("post_rst i_rvalid", 32'(i_rvalid), 32'd0);
        check("post_rst d_rvalid", 32'(d_rvalid), 32'd0);
      end
      check($sformatf("post_rst%0d i_gnt", k), 32'(i_gnt), 32'(k == 4));
      check($sformatf("post_rst%0d d_gnt", k), 32'(d_gnt), 32'(k != 4));
      next_cycle();
    end

    drive(0, 0, 0, 0, 0, 0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_unified_mem_arbiter
